// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared owner encoding and default constants for the memory port arbiter
package mem_port_arbiter_pkg;
   localparam int DATA_WIDTH_DEF = 16;
   localparam logic [15:0] LED_ADDR_DEF = 16'h3FFF;
   typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU_RD, OWN_CPU_LED} owner_e;
endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// starve_counter: saturating 4-bit count of consecutive CPU denials with limit compare
module starve_counter #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   logic [3:0] cnt_q, cnt_d;
   // clear wins over increment; increment saturates at 15
   always_comb begin
      cnt_d = clr ? 4'd0 : inc ? ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1) : cnt_q;
      at_limit = cnt_q >= 4'(LIMIT);
   end
   // counter register
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the RAM port between CPU and scanner, decodes the LED register
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic [15:0] LED_ADDR = LED_ADDR_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [15:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  vid_req,
   input  logic [15:0]           vid_addr,
   output logic                  vid_gnt,
   output logic                  vid_rvalid,
   output logic [DATA_WIDTH-1:0] vid_rdata,
   output logic [15:0]           mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic [7:0]            led
);
   owner_e owner_q, owner_d;
   logic [7:0] led_q, led_d, led_cap_q, led_cap_d;
   logic [DATA_WIDTH-1:0] cpu_hold_q, vid_hold_q;
   logic at_limit, is_led;

   starve_counter #(.LIMIT(STARVE_LIMIT)) u_sc (
      .clk      (clk),
      .reset    (reset),
      .inc      (cpu_req & ~cpu_gnt),
      .clr      (~cpu_req | cpu_gnt),
      .at_limit (at_limit)
   );

   // scanner has priority unless the CPU has been starved; the port follows the grant
   always_comb begin
      is_led = cpu_addr == LED_ADDR;
      vid_gnt = ~reset & vid_req & ~(cpu_req & at_limit);
      cpu_gnt = ~reset & cpu_req & (at_limit | ~vid_req);
      mem_addr = cpu_gnt ? cpu_addr : vid_addr;
      mem_we = cpu_gnt & cpu_we & ~is_led;
      mem_din = cpu_wdata;
   end

   // next owner from this cycle's grant; the LED value is captured at a LED load grant
   always_comb begin
      owner_d = vid_gnt ? OWN_VID : (cpu_gnt & ~cpu_we) ? (is_led ? OWN_CPU_LED : OWN_CPU_RD) : OWN_NONE;
      led_d = (cpu_gnt & cpu_we & is_led) ? cpu_wdata[7:0] : led_q;
      led_cap_d = (cpu_gnt & ~cpu_we & is_led) ? led_q : led_cap_q;
   end

   // owner state, LED register and read-data hold registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         owner_q <= OWN_NONE;
         led_q <= '0;
         led_cap_q <= '0;
         cpu_hold_q <= '0;
         vid_hold_q <= '0;
      end else begin
         owner_q <= owner_d;
         led_q <= led_d;
         led_cap_q <= led_cap_d;
         cpu_hold_q <= cpu_rdata;
         vid_hold_q <= vid_rdata;
      end

   // responses are steered by the registered owner; rdata holds when nothing returns
   always_comb begin
      cpu_rvalid = (owner_q == OWN_CPU_RD) | (owner_q == OWN_CPU_LED);
      vid_rvalid = owner_q == OWN_VID;
      cpu_rdata = (owner_q == OWN_CPU_RD) ? mem_dout : (owner_q == OWN_CPU_LED) ? DATA_WIDTH'(led_cap_q) : cpu_hold_q;
      vid_rdata = vid_rvalid ? mem_dout : vid_hold_q;
      led = led_q;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a queue scoreboard for read responses
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic vid_req, vid_gnt, vid_rvalid;
   logic [15:0] vid_addr, vid_rdata;
   logic [15:0] mem_addr, mem_din, mem_dout;
   logic mem_we;
   logic [7:0] led;
   logic [15:0] ram [256];
   logic rv [256];
   logic [15:0] cq [$];
   logic [15:0] vq [$];
   int tests = 0;
   int fails = 0;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
      .led(led)
   );

   always #5 clk = ~clk;

   // synchronous-read RAM; unwritten words read as {B0, low address byte}
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) rv[i] <= 1'b0;
      end else begin
         if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_din;
            rv[mem_addr[7:0]] <= 1'b1;
         end
         mem_dout <= rv[mem_addr[7:0]] ? ram[mem_addr[7:0]] : {8'hB0, mem_addr[7:0]};
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                        input logic vr, input logic [15:0] va);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      vid_req = vr; vid_addr = va;
      #1;
   endtask

   // scoreboard monitor: every rvalid must match the oldest expected response
   always @(negedge clk) begin
      if (cpu_rvalid) begin
         if (cq.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 0);
         else chk("cpu_rdata", 32'(cpu_rdata), 32'(cq.pop_front()));
      end
      if (vid_rvalid) begin
         if (vq.size() == 0) chk("vid_rvalid_unexpected", 32'(vid_rvalid), 0);
         else chk("vid_rdata", 32'(vid_rdata), 32'(vq.pop_front()));
      end
   end

   initial begin
      drive(1, 1, 16'h0010, 16'h00A5, 1, 16'h0020);
      chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("rst_vid_gnt", 32'(vid_gnt), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) cyc;
      reset = 1'b0;
      cyc;
      chk("idle_cpu_gnt", 32'(cpu_gnt), 0);
      chk("idle_vid_gnt", 32'(vid_gnt), 0);
      chk("idle_mem_we", 32'(mem_we), 0);
      chk("idle_led", 32'(led), 0);
      chk("idle_cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("idle_vid_rvalid", 32'(vid_rvalid), 0);
      chk("idle_cpu_rdata", 32'(cpu_rdata), 0);
      chk("idle_vid_rdata", 32'(vid_rdata), 0);
      // RAM store then load
      drive(1, 1, 16'h0010, 16'h00A5, 0, 0);
      chk("st_gnt", 32'(cpu_gnt), 1);
      chk("st_we", 32'(mem_we), 1);
      chk("st_addr", 32'(mem_addr), 32'h0010);
      chk("st_din", 32'(mem_din), 32'h00A5);
      cyc;
      drive(1, 0, 16'h0010, 0, 0, 0);
      chk("ld_gnt", 32'(cpu_gnt), 1);
      chk("ld_we", 32'(mem_we), 0);
      cq.push_back(16'h00A5);
      cyc;
      drive(0, 0, 0, 0, 0, 0);
      chk("after_ld_we", 32'(mem_we), 0);
      cyc;
      // LED store then load
      drive(1, 1, 16'h3FFF, 16'h1234, 0, 0);
      chk("led_st_gnt", 32'(cpu_gnt), 1);
      chk("led_st_we", 32'(mem_we), 0);
      cyc;
      chk("led_val", 32'(led), 32'h34);
      drive(1, 0, 16'h3FFF, 0, 0, 0);
      chk("led_ld_gnt", 32'(cpu_gnt), 1);
      chk("led_ld_we", 32'(mem_we), 0);
      cq.push_back(16'h0034);
      cyc;
      drive(0, 0, 0, 0, 0, 0);
      cyc;
      // continuous scanner traffic starves the CPU for four cycles each time
      drive(1, 0, 16'h0010, 0, 1, 16'h0020);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 5; i++) begin
            if (r == 1 && i == 0) chk("starve_cleared", 32'(dut.u_sc.cnt_q), 0);
            if (i < 4) begin
               chk("starve_vid_gnt", 32'(vid_gnt), 1);
               chk("starve_cpu_gnt", 32'(cpu_gnt), 0);
               vq.push_back(16'hB020);
            end else begin
               chk("starve_cnt_lim", 32'(dut.u_sc.cnt_q), 4);
               chk("starve_cpu_win", 32'(cpu_gnt), 1);
               chk("starve_vid_off", 32'(vid_gnt), 0);
               cq.push_back(16'h00A5);
            end
            cyc;
         end
      end
      drive(0, 0, 0, 0, 0, 0);
      cyc;
      // alternating single requests
      drive(0, 0, 0, 0, 1, 16'h0021);
      chk("alt_vid_gnt", 32'(vid_gnt), 1);
      chk("alt_vid_addr", 32'(mem_addr), 32'h0021);
      vq.push_back(16'hB021);
      cyc;
      drive(1, 0, 16'h0010, 0, 0, 0);
      chk("alt_cpu_gnt", 32'(cpu_gnt), 1);
      cq.push_back(16'h00A5);
      cyc;
      drive(0, 0, 0, 0, 1, 16'h0022);
      chk("alt_vid_gnt2", 32'(vid_gnt), 1);
      vq.push_back(16'hB022);
      cyc;
      drive(1, 0, 16'h3FFF, 0, 0, 0);
      chk("alt_cpu_gnt2", 32'(cpu_gnt), 1);
      cq.push_back(16'h0034);
      cyc;
      drive(0, 0, 0, 0, 0, 0);
      cyc;
      // reset right after a CPU load grant drops the response
      drive(1, 0, 16'h0010, 0, 0, 0);
      chk("rl_gnt", 32'(cpu_gnt), 1);
      cyc;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk("rl_rvalid", 32'(cpu_rvalid), 0);
      chk("rl_led", 32'(led), 0);
      chk("rl_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rl_vid_rdata", 32'(vid_rdata), 0);
      cyc;
      reset = 1'b0;
      repeat (2) cyc;
      // reset clears a partially accumulated starvation count
      drive(1, 0, 16'h0010, 0, 1, 16'h0020);
      chk("sc_vid_gnt_a", 32'(vid_gnt), 1);
      vq.push_back(16'hB020);
      cyc;
      chk("sc_vid_gnt_b", 32'(vid_gnt), 1);
      cyc;
      chk("sc_pre", 32'(dut.u_sc.cnt_q), 2);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      chk("sc_rst", 32'(dut.u_sc.cnt_q), 0);
      cyc;
      reset = 1'b0;
      cyc;
      drive(1, 0, 16'h0010, 0, 1, 16'h0020);
      chk("post_vid_gnt", 32'(vid_gnt), 1);
      chk("post_cpu_gnt", 32'(cpu_gnt), 0);
      vq.push_back(16'hB020);
      cyc;
      drive(1, 0, 16'h0010, 0, 0, 0);
      chk("post_cpu_gnt2", 32'(cpu_gnt), 1);
      cq.push_back(16'hB010);
      cyc;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) cyc;
      chk("cq_empty", 32'(cq.size()), 0);
      chk("vq_empty", 32'(vq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the data-memory second port between the CPU load/store path and the display scanner, which reads frame-buffer words for the Tron playfield. It also decodes the memory-mapped LED register so CPU stores to it never reach RAM. The block sits between the two requesters and the RAM's synchronous-read port (registered address, data valid the following cycle).

## Interface
- DATA_WIDTH, 16, word width of all data buses
- LED_ADDR, 16'h3FFF, CPU address decoded as the LED register instead of RAM
- STARVE_LIMIT, 4, consecutive CPU denials after which the CPU wins once (range 1–15)

Clock and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_gnt  out  1  combinational; CPU access accepted this cycle
- cpu_rvalid  out  1  load data valid (registered)
- cpu_rdata  out  DATA_WIDTH  load data
- vid_req  in  1  scanner read request; held until vid_gnt
- vid_addr  in  16  scanner word address
- vid_gnt  out  1  combinational; scanner read accepted
- vid_rvalid  out  1  scanner data valid (registered)
- vid_rdata  out  DATA_WIDTH  scanner data
- mem_addr  out  16  RAM port address
- mem_we  out  1  RAM port write enable
- mem_din  out  DATA_WIDTH  RAM write data
- mem_dout  in  DATA_WIDTH  RAM read data, valid one cycle after the address is presented
- led  out  8  LED register

## Operation
- Arbitration is evaluated every cycle from the current requests and the starvation counter `starve_cnt` (4 bits).
- Default priority goes to the scanner: if vid_req=1, vid_gnt=1.
- Exception: if cpu_req=1 and starve_cnt ≥ STARVE_LIMIT, then cpu_gnt=1 and vid_gnt=0.
- At most one grant is asserted per cycle. No grant is asserted without the matching request.
- Starvation counter:
  - cpu_req=1 and not granted: starve_cnt increments, saturating at 15.
  - CPU granted, or cpu_req=0: starve_cnt clears to 0.
- Port mux:
  - Scanner granted: mem_addr=vid_addr, mem_we=0.
  - CPU granted: mem_addr=cpu_addr, mem_din=cpu_wdata, mem_we=cpu_we AND (cpu_addr≠LED_ADDR).
  - No grant: mem_we=0; mem_addr holds the scanner address.
- CPU store to LED_ADDR: led ← cpu_wdata[7:0] at that clock edge; RAM is not written.
- CPU load from LED_ADDR: cpu_rdata = {8'h00, led}, sampled from the led value at the grant edge.
- Response tracking uses a registered owner state with four values, updated every edge from the current grant:
  - NONE: no grant.
  - VID: scanner read granted.
  - CPU_RD: CPU load from RAM granted.
  - CPU_LED: CPU load from LED_ADDR granted.
  - A CPU store sets NONE (stores produce no rvalid).
- Response outputs:
  - VID: vid_rvalid=1, vid_rdata=mem_dout.
  - CPU_RD: cpu_rvalid=1, cpu_rdata=mem_dout.
  - CPU_LED: cpu_rvalid=1, cpu_rdata is the captured LED value.
  - Otherwise: both rvalid outputs are 0, and the rdata outputs hold their last values.

## Timing
- Reset values:
  - starve_cnt=0, owner=NONE, led=8'h00.
  - cpu_rvalid=0, vid_rvalid=0, cpu_rdata=0, vid_rdata=0.
  - cpu_gnt=0, vid_gnt=0 and mem_we=0, forced while reset is high.
- Load latency: grant in cycle N, rvalid and rdata in cycle N+1. Back-to-back grants give one response per cycle.
- Store: takes effect at the edge ending the grant cycle. A load of the same address granted in the next cycle returns the new data.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: scanner wins. With a continuous scanner request, the CPU is granted every STARVE_LIMIT+1 cycles.
- Reset asserted mid-access: the pending response is dropped (no rvalid after reset releases), and an in-flight LED store is lost.
- A requester must not change addr, we or wdata while req=1 and gnt=0.

## Structure
- The shared package holds:
  - the owner-state enumeration (NONE, VID, CPU_RD, CPU_LED);
  - the LED_ADDR default constant;
  - the DATA_WIDTH default constant.
- One natural sub-module, `starve_counter`: a saturating counter with clear, increment and limit-compare. Everything else is a single module.

## Test plan
- Reset, then idle: all grants, rvalid and mem_we are 0; led=00.
- CPU alone stores 16'h00A5 to 16'h0010, then loads 16'h0010: mem_we=1 only in the store cycle; cpu_rvalid in the cycle after the load grant with cpu_rdata=00A5.
- CPU stores 16'h1234 to LED_ADDR, then loads LED_ADDR: led=34, mem_we stays 0, cpu_rdata=0034.
- Scanner requests continuously while the CPU requests a load: CPU is denied for 4 cycles, granted in the 5th, then starve_cnt returns to 0; vid_rvalid is asserted in every cycle following a vid_gnt.
- Scanner and CPU alternate single requests with no overlap: each is granted immediately; rdata is returned to the correct port with 1-cycle latency.
- Reset asserted the cycle after a CPU load grant: cpu_rvalid stays 0; counters and led are cleared.
